lsu_mem_ctrl: RTL and testbench

- Load/store controller between the execute stage and data memory.
- Drives a valid/grant/rvalid memory bus and stalls the core while a transaction is in flight.
- Sign- or zero-extends load data into a registered output that feeds the "memory read data" input of the writeback result-select mux.
- Flags misaligned, illegal and timed-out accesses instead of issuing or completing them.

---
 rtl/lsu_mem_ctrl_if.sv | 25 ++
 rtl/lsu_mem_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_ctrl_if.sv
// Memory-side bus of the load/store controller: a request/grant phase
// followed by a response (rvalid) phase that acknowledges loads and stores.
interface lsu_mem_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [3:0]            mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between execute and data memory. Accepts one RV32
// load/store at a time, drives the memory bus, stalls the core while the
// access is in flight and returns an extended, registered load result.
// Illegal, misaligned and timed-out accesses complete with a flag instead.
// Byte-lane logic assumes a 32-bit data bus (4 lanes).
module lsu_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned,
  output logic                  bus_err,
  lsu_mem_ctrl_if.master        mem
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES >= 2).
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [CW-1:0]         cnt;
  logic [2:0]            op_funct3;
  logic [1:0]            op_lane;

  logic                  req_illegal;
  logic                  req_misal;
  logic                  issue;
  logic                  set_mis;
  logic                  set_err;
  logic                  complete;
  logic                  timeout;
  logic                  drop_req;
  logic [3:0]            be_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [DATA_WIDTH-1:0] rdata_shift;
  logic [DATA_WIDTH-1:0] load_ext;

  // Reserved size encodings and unsigned stores are rejected outright.
  assign req_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                       (req_funct3 == 3'b111) | (req_we & req_funct3[2]);

  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    req_misal = 1'b0;
    case (req_funct3[1:0])
      2'b01:   req_misal = req_addr[0];
      2'b10:   req_misal = |req_addr[1:0];
      default: req_misal = 1'b0;
    endcase
  end

  // Next-state and one-cycle control decisions for the access FSM.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    set_mis   = 1'b0;
    set_err   = 1'b0;
    complete  = 1'b0;
    timeout   = 1'b0;
    drop_req  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && en) begin
          if (req_illegal) begin
            set_err   = 1'b1;
            state_nxt = DONE;
          end else if (req_misal) begin
            set_mis   = 1'b1;
            state_nxt = DONE;
          end else begin
            issue     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_gnt && mem.mem_rvalid) begin
          complete  = 1'b1;
          drop_req  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          drop_req  = 1'b1;
          state_nxt = DONE;
        end else if (mem.mem_gnt) begin
          drop_req  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem.mem_rvalid) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stall holds the PC while a request is being accepted or is in flight;
  // it is low in DONE so the PC advances on the completing edge.
  assign stall = rstn & (((state == IDLE) & req_valid & en) |
                         (state == REQ) | (state == WAIT));

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_nxt    = 4'b0001 << req_addr[1:0];
        wdata_nxt = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_nxt    = 4'b0011 << req_addr[1:0];
        wdata_nxt = {2{req_wdata[15:0]}};
      end
      default: begin
        be_nxt    = 4'b1111;
        wdata_nxt = req_wdata;
      end
    endcase
  end

  // Pick the addressed byte/halfword out of the read word and extend it.
  always_comb begin
    rdata_shift = mem.mem_rdata >> {op_lane, 3'b000};
    load_ext    = mem.mem_rdata;
    case (op_funct3)
      3'b000:  load_ext = {{(DATA_WIDTH-8){rdata_shift[7]}}, rdata_shift[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){rdata_shift[15]}}, rdata_shift[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, rdata_shift[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, rdata_shift[15:0]};
      default: load_ext = mem.mem_rdata;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timeout counter: cleared on issue, advances every REQ/WAIT cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (issue) begin
      cnt <= '0;
    end else if ((state == REQ) || (state == WAIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Bus request registers: latched on issue, request dropped on grant or timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_be    <= 4'b0000;
      mem.mem_wdata <= '0;
      op_funct3     <= 3'b000;
      op_lane       <= 2'b00;
    end else if (issue) begin
      mem.mem_req   <= 1'b1;
      mem.mem_we    <= req_we;
      mem.mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      mem.mem_be    <= be_nxt;
      mem.mem_wdata <= wdata_nxt;
      op_funct3     <= req_funct3;
      op_lane       <= req_addr[1:0];
    end else if (drop_req || timeout) begin
      mem.mem_req   <= 1'b0;
    end
  end

  // Completion pulse, status flags and the held load result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      load_data  <= '0;
    end else begin
      done       <= (state_nxt == DONE);
      misaligned <= set_mis;
      bus_err    <= set_err | timeout;
      if (complete && !mem.mem_we) begin
        load_data <= load_ext;
      end else if (set_err || timeout) begin
        load_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, a few multi-cycle
// sequences and randomized accesses against a behavioural model.
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  lsu_mem_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_mem_ctrl #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .done      (done),
    .load_data (load_data),
    .misaligned(misaligned),
    .bus_err   (bus_err),
    .mem       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          gntDelay;
    int          rvDelay;
    logic        enLow;
    logic [31:0] expLoad;
    logic        expMis;
    logic        expErr;
    logic        expBus;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    int          expCycles;
  } vec_t;

  typedef struct {
    logic        gotDone;
    int          cycles;
    int          stallCycles;
    logic        stallInDone;
    logic        doneAfter;
    logic        reqSeen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic        mis;
    logic        err;
    logic [31:0] load;
  } obs_t;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expLoad;
  vec_t        vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input int gd, input int rd, input logic [31:0] eLoad,
                                 input logic eMis, input logic eErr, input logic eBus,
                                 input logic [3:0] eBe, input logic [31:0] eWdata, input int eCyc);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.gntDelay = gd; v.rvDelay = rd; v.enLow = 1'b0;
    v.expLoad = eLoad; v.expMis = eMis; v.expErr = eErr; v.expBus = eBus;
    v.expBe = eBe; v.expWdata = eWdata; v.expCycles = eCyc;
    return v;
  endfunction

  // Reference behaviour: access size in bytes, alignment by modulo, latency
  // as 1 accept cycle plus bus cycles capped at the timeout.
  function automatic vec_t model(input vec_t v, input logic [31:0] prevLoad);
    vec_t        r;
    int          bytes;
    int          lane;
    int          total;
    int          mask;
    logic [31:0] shifted;
    logic [31:0] val;
    logic        illegal;
    r = v;
    lane  = int'(v.addr[1:0]);
    bytes = 1 << v.f3[1:0];
    illegal = (v.f3 == 3'd3) || (v.f3 == 3'd6) || (v.f3 == 3'd7) || (v.we && v.f3[2]);
    r.expMis = 1'b0; r.expErr = 1'b0; r.expBus = 1'b0; r.expLoad = prevLoad;
    r.expBe = 4'b0000; r.expWdata = 32'h0;
    if (illegal) begin
      r.expErr = 1'b1; r.expLoad = 32'h0; r.expCycles = 1;
    end else if ((lane % bytes) != 0) begin
      r.expMis = 1'b1; r.expCycles = 1;
    end else begin
      r.expBus = 1'b1;
      mask = ((1 << bytes) - 1) << lane;
      r.expBe = mask[3:0];
      for (int i = 0; i < 4; i++) r.expWdata[8*i +: 8] = v.wdata[8*(i % bytes) +: 8];
      total = v.gntDelay + 1 + v.rvDelay;
      if (total > TIMEOUT) begin
        r.expErr = 1'b1; r.expLoad = 32'h0; r.expCycles = 1 + TIMEOUT;
      end else begin
        r.expCycles = 1 + total;
        if (!v.we) begin
          shifted = v.rdata >> (8 * lane);
          if (bytes == 1) begin
            val = {24'h0, shifted[7:0]};
            if (!v.f3[2] && shifted[7]) val = val | 32'hFFFF_FF00;
          end else if (bytes == 2) begin
            val = {16'h0, shifted[15:0]};
            if (!v.f3[2] && shifted[15]) val = val | 32'hFFFF_0000;
          end else begin
            val = v.rdata;
          end
          r.expLoad = val;
        end
      end
    end
    return r;
  endfunction

  function automatic vec_t mkRandom();
    vec_t v;
    int   pick;
    pick = $urandom_range(0, 9);
    v.f3 = (pick == 8) ? 3'b010 : (pick == 9) ? 3'b000 : 3'(pick);
    v.we = 1'($urandom_range(0, 1));
    v.addr = ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
    v.wdata = $urandom;
    v.rdata = $urandom;
    v.gntDelay = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 18) : $urandom_range(0, 3);
    v.rvDelay  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 17) : $urandom_range(0, 3);
    v.enLow = ($urandom_range(0, 3) == 0);
    return v;
  endfunction

  // Drives one access and plays the memory side with the vector's delays.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    int   reqCnt  = 0;
    int   waitCnt = 0;
    logic gntSeen = 1'b0;
    o = '{default: 0};
    @(negedge clk);
    en = 1'b1; req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
    req_addr = v.addr; req_wdata = v.wdata;
    for (int c = 1; c <= 60; c++) begin
      bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = $urandom;
      if (!gntSeen && bus.mem_req) begin
        if (!o.reqSeen) begin
          o.reqSeen = 1'b1; o.addr = bus.mem_addr; o.be = bus.mem_be;
          o.wdata = bus.mem_wdata; o.we = bus.mem_we;
        end
        if (reqCnt == v.gntDelay) begin
          bus.mem_gnt = 1'b1; gntSeen = 1'b1;
          if (v.rvDelay == 0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = v.rdata; end
        end
        reqCnt++;
      end else if (gntSeen) begin
        waitCnt++;
        if (waitCnt == v.rvDelay) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = v.rdata; end
      end
      #1;
      if (stall) o.stallCycles++;
      @(posedge clk);
      @(negedge clk);
      if (c == 1 && v.enLow) en = 1'b0;
      if (done) begin
        o.gotDone = 1'b1; o.cycles = c; o.mis = misaligned; o.err = bus_err; o.load = load_data;
        break;
      end
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    #1;
    o.stallInDone = stall;
    req_valid = 1'b0; en = 1'b1;
    @(negedge clk);
    o.doneAfter = done;
  endtask

  task automatic checkTxn(input string tag, input vec_t e, input obs_t o);
    checkOutput({tag, " done seen"}, 32'(o.gotDone), 32'd1);
    checkOutput({tag, " latency"}, o.cycles, e.expCycles);
    checkOutput({tag, " stall cycles"}, o.stallCycles, e.expCycles);
    checkOutput({tag, " stall in DONE"}, 32'(o.stallInDone), 32'd0);
    checkOutput({tag, " done one cycle"}, 32'(o.doneAfter), 32'd0);
    checkOutput({tag, " misaligned"}, 32'(o.mis), 32'(e.expMis));
    checkOutput({tag, " bus_err"}, 32'(o.err), 32'(e.expErr));
    checkOutput({tag, " load_data"}, o.load, e.expLoad);
    checkOutput({tag, " mem_req seen"}, 32'(o.reqSeen), 32'(e.expBus));
    if (e.expBus && o.reqSeen) begin
      checkOutput({tag, " mem_addr"}, o.addr, {e.addr[31:2], 2'b00});
      checkOutput({tag, " mem_be"}, 32'(o.be), 32'(e.expBe));
      checkOutput({tag, " mem_we"}, 32'(o.we), 32'(e.we));
      if (e.we) checkOutput({tag, " mem_wdata"}, o.wdata, e.expWdata);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    obs_t o;
    vec_t e;
    rstn = 1'b1; en = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset misaligned", 32'(misaligned), 32'd0);
    checkOutput("reset bus_err", 32'(bus_err), 32'd0);
    checkOutput("reset load_data", load_data, 32'd0);
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset mem_req", 32'(bus.mem_req), 32'd0);
    checkOutput("reset mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("reset mem_addr", bus.mem_addr, 32'd0);
    checkOutput("reset mem_be", 32'(bus.mem_be), 32'd0);
    checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
    rstn = 1'b1;
    expLoad = 32'h0;

    //              we  f3      addr          wdata         rdata         gd  rd  load          mis   err   bus   be       wdata         cyc
    vecs[0]  = mkVec(0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0,  1, 32'h0000_0080, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,        3);
    vecs[1]  = mkVec(0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_0000, 0,  0, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0,        2);
    vecs[2]  = mkVec(1, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,        1,  1, 32'hFFFF_8001, 1'b0, 1'b0, 1'b1, 4'b0010, 32'hABAB_ABAB, 4);
    vecs[3]  = mkVec(0, 3'b010, 32'h0000_0302, 32'h0,        32'h0,         0,  0, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1);
    vecs[4]  = mkVec(0, 3'b011, 32'h0000_0300, 32'h0,        32'h0,         0,  0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[5]  = mkVec(0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_9A00, 0,  2, 32'hFFFF_FF9A, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0,        4);
    vecs[6]  = mkVec(1, 3'b010, 32'h0000_0400, 32'h1234_5678, 32'h0,        2,  0, 32'hFFFF_FF9A, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h1234_5678, 4);
    vecs[7]  = mkVec(0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_0000, 1,  0, 32'h0000_8001, 1'b0, 1'b0, 1'b1, 4'b1100, 32'h0,        3);
    vecs[8]  = mkVec(1, 3'b100, 32'h0000_0010, 32'h0000_0055, 32'h0,        0,  0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        1);
    vecs[9]  = mkVec(0, 3'b010, 32'h0000_0500, 32'h0,        32'hCAFE_BABE, 15, 0, 32'hCAFE_BABE, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        17);
    vecs[10] = mkVec(0, 3'b010, 32'h0000_0600, 32'h0,        32'h1122_3344, 14, 1, 32'h1122_3344, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0,        17);
    vecs[11] = mkVec(0, 3'b010, 32'h0000_0604, 32'h0,        32'h5566_7788, 14, 2, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0,        17);
    vecs[12] = mkVec(1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0,  3, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 5);
    vecs[13] = mkVec(0, 3'b001, 32'h0000_0203, 32'h0,        32'h0,         0,  0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        1);
    vecs[14] = mkVec(0, 3'b010, 32'h0000_0308, 32'h0,        32'h0,         99, 0, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0,        17);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i], o);
      checkTxn($sformatf("vec%0d", i), vecs[i], o);
      expLoad = vecs[i].expLoad;
    end

    // A response arriving after the timeout must not complete anything.
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    checkOutput("late rvalid done", 32'(done), 32'd0);
    checkOutput("late rvalid load_data", load_data, 32'd0);
    checkOutput("late rvalid mem_req", 32'(bus.mem_req), 32'd0);

    for (int n = 0; n < 200; n++) begin
      e = model(mkRandom(), expLoad);
      applyStimulus(e, o);
      checkTxn($sformatf("rnd%0d", n), e, o);
      expLoad = e.expLoad;
    end

    // Reset in WAIT aborts the access; a late response and en=0 are both ignored.
    @(negedge clk);
    en = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0700;
    @(negedge clk);
    checkOutput("rstseq mem_req in REQ", 32'(bus.mem_req), 32'd1);
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    checkOutput("rstseq mem_req in WAIT", 32'(bus.mem_req), 32'd0);
    checkOutput("rstseq stall in WAIT", 32'(stall), 32'd1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rstseq stall", 32'(stall), 32'd0);
    checkOutput("rstseq done", 32'(done), 32'd0);
    checkOutput("rstseq misaligned", 32'(misaligned), 32'd0);
    checkOutput("rstseq bus_err", 32'(bus_err), 32'd0);
    checkOutput("rstseq load_data", load_data, 32'd0);
    checkOutput("rstseq mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("rstseq mem_addr", bus.mem_addr, 32'd0);
    checkOutput("rstseq mem_be", 32'(bus.mem_be), 32'd0);
    checkOutput("rstseq mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    rstn = 1'b1; en = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1357_9BDF;
    #1;
    checkOutput("en0 stall", 32'(stall), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      checkOutput($sformatf("en0 done c%0d", k), 32'(done), 32'd0);
      checkOutput($sformatf("en0 mem_req c%0d", k), 32'(bus.mem_req), 32'd0);
      checkOutput($sformatf("en0 load_data c%0d", k), load_data, 32'd0);
      checkOutput($sformatf("en0 stall c%0d", k), 32'(stall), 32'd0);
    end
    en = 1'b1;
    #1;
    checkOutput("en1 stall", 32'(stall), 32'd1);
    req_valid = 1'b0;
    #1;
    checkOutput("en1 stall no req", 32'(stall), 32'd0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
